prog_mem_ctrl: RTL
==================

// Module: prog_mem_ctrl
// PURPOSE
//  Sequences the shared instruction-memory write port between the CPU and the JTAG byte loader.
//  Detects a JTAG programming session, holds the CPU in reset and revokes its grant for the session.
//  Packs loader bytes into 32-bit byte-enabled word writes and flushes any partial word at session end.
//  Releases the CPU after a fixed reset tail. Sits between the JTAG loader, the CPU and the imem write port.
// PARAMETERS
//  RELEASE_CYCLES  16  cycles cpu_rst_no stays low after a session ends (>=1)
//  SYNC_STAGES     2   flops in the jtag_sel_i synchroniser (>=2)
// PORTS
//  clk_i        in   1   system clock; the only clock
//  rst_ni       in   1   reset, asynchronous, active-low
//  jtag_sel_i   in   1   USER chain selected; TCK domain, async to clk_i
//  jtag_we_i    in   1   loader byte valid; clk_i domain level, high for >=1 cycle per byte
//  jtag_data_i  in   8   loader byte; stable while jtag_we_i high
//  jtag_addr_i  in   10  loader byte address; [9:2] word, [1:0] lane
//  cpu_req_i    in   1   CPU write request
//  cpu_addr_i   in   8   CPU word address
//  cpu_wdata_i  in   32  CPU write data
//  cpu_be_i     in   4   CPU byte enables
//  cpu_gnt_o    out  1   CPU owns the port this cycle
//  cpu_rst_no   out  1   CPU reset, active-low
//  mem_we_o     out  1   imem write strobe
//  mem_addr_o   out  8   imem word address
//  mem_wdata_o  out  32  imem write data; lane k = bits [8k+7:8k]
//  mem_be_o     out  4   imem byte enables
//  busy_o       out  1   high in every state except RUN
//  prog_done_o  out  1   1-cycle pulse on RELEASE->RUN
//  checksum_o   out  8   session byte checksum (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=RELEASE, cnt=0, pend_be=0, cpu_rst_no=0, cpu_gnt_o=0, mem_*=0, prog_done_o=0, checksum_o=0.
//  - sel_s = jtag_sel_i after SYNC_STAGES flops.
//  - Byte capture: on rising edge of jtag_we_i (we & !we_q) only. Level-held we is never recaptured.
//  - States:
//    - RUN: cpu_rst_no=1, cpu_gnt_o=1. mem_we_o=cpu_req_i; addr/wdata/be driven combinationally from the CPU.
//      sel_s high -> PROG.
//    - PROG: cpu_rst_no=0, cpu_gnt_o=0, CPU requests dropped. On entry, pend_be=0 and checksum is cleared.
//      Capture of byte at lane L, word W:
//        pend_be!=0 and W!=pend_addr: write pending word next cycle (be=pend_be), then start buffer {W, lane L}.
//        Otherwise merge into buffer; if pend_be becomes 4'hF, write next cycle and clear pend_be.
//      Write timing: mem_we_o is high for exactly 1 cycle, the cycle after capture (registered).
//      sel_s low -> FLUSH. A capture in that same cycle is merged first.
//    - FLUSH (1 cycle): if pend_be!=0, mem_we_o=1 with pend_addr/pend_be. Clear pend_be. -> RELEASE, cnt=0.
//    - RELEASE: cpu_rst_no=0, cnt++. cnt==RELEASE_CYCLES-1 -> RUN with prog_done_o=1 for that one cycle.
//      sel_s high -> PROG (restart; cnt cleared).
//  - Bytes rising outside PROG are ignored.
//  - Non-written lanes of mem_wdata_o are 0 outside RUN.
//  - Async reset mid-session: the pending partial word is discarded, never written.
// CONFIGURATION
//  PROG_CHECKSUM_EN defined:
//    checksum_o = sum mod 256 of all bytes captured in the current session.
//    Cleared on PROG entry; held through RELEASE/RUN.
//  PROG_CHECKSUM_EN undefined:
//    checksum_o tied 0; no adder or register instantiated.
// TESTING
//  1. Reset with RELEASE_CYCLES=16 -> cpu_rst_no=0 for 16 cycles after rst_ni rises, then prog_done_o 1-cycle pulse, busy_o=0.
//  2. sel up; bytes 11,22,33,44 @ addr 0..3 -> one write: addr 0, wdata 0x44332211, be F; cpu_gnt_o=0 throughout.
//  3. Six bytes 11..66 @ addr 0..5, then sel down -> FLUSH writes addr 1, wdata 0x00006655, be 3; then RELEASE.
//  4. we held high 5 cycles per byte, and a jump addr 3 -> 8 -> exactly one capture per byte; word 0 flushed with be 8 before word 2.
//  5. RUN: cpu_req addr 7, be 5 -> passes through same cycle. In PROG: no mem_we_o from CPU. sel re-rise in RELEASE -> PROG, cpu_rst_no stays 0.
//  6. Macro on: bytes FF,02 -> checksum_o=01, cleared on next session start. Macro off: checksum_o=0.

Source files
------------

// File: rtl/prog_mem_ctrl.sv
// ---------------------------------------------------------------------------
// prog_mem_ctrl
//
// Shares the instruction-memory write port between the CPU and the JTAG byte
// loader. When the loader's USER chain is selected, a programming session
// starts. For the whole session the CPU is held in reset and loses its grant.
// Loader bytes are packed into 32-bit byte-enabled word writes. Any partial
// word still buffered when the session ends is flushed. The CPU is then held
// in reset for a fixed tail before it is released.
//
// Parameters
//   RELEASE_CYCLES  cycles cpu_rst_no stays low after a session ends (>=1)
//   SYNC_STAGES     flops in the jtag_sel_i synchroniser (>=2)
//
// Optional feature
//   PROG_CHECKSUM_EN  when defined, checksum_o is the mod-256 sum of every
//                     byte captured in the current session. When undefined,
//                     checksum_o is tied to zero.
//
// Ports
//   clk_i        in   1   system clock
//   rst_ni       in   1   asynchronous active-low reset
//   jtag_sel_i   in   1   USER chain selected (TCK domain, synchronised here)
//   jtag_we_i    in   1   loader byte valid (level, clk_i domain)
//   jtag_data_i  in   8   loader byte
//   jtag_addr_i  in   10  loader byte address: [9:2] word, [1:0] lane
//   cpu_req_i    in   1   CPU write request
//   cpu_addr_i   in   8   CPU word address
//   cpu_wdata_i  in   32  CPU write data
//   cpu_be_i     in   4   CPU byte enables
//   cpu_gnt_o    out  1   CPU owns the write port this cycle
//   cpu_rst_no   out  1   CPU reset, active-low
//   mem_we_o     out  1   imem write strobe
//   mem_addr_o   out  8   imem word address
//   mem_wdata_o  out  32  imem write data, lane k = bits [8k+7:8k]
//   mem_be_o     out  4   imem byte enables
//   busy_o       out  1   high whenever the controller is not in RUN
//   prog_done_o  out  1   single-cycle pulse on the first cycle of RUN
//   checksum_o   out  8   session byte checksum
// ---------------------------------------------------------------------------
module prog_mem_ctrl #(
   parameter int RELEASE_CYCLES = 16,
   parameter int SYNC_STAGES    = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        jtag_sel_i,
   input  logic        jtag_we_i,
   input  logic [7:0]  jtag_data_i,
   input  logic [9:0]  jtag_addr_i,
   input  logic        cpu_req_i,
   input  logic [7:0]  cpu_addr_i,
   input  logic [31:0] cpu_wdata_i,
   input  logic [3:0]  cpu_be_i,
   output logic        cpu_gnt_o,
   output logic        cpu_rst_no,
   output logic        mem_we_o,
   output logic [7:0]  mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   output logic        busy_o,
   output logic        prog_done_o,
   output logic [7:0]  checksum_o
);

   localparam int CNT_W = $clog2(RELEASE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELEASE_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      PROG    = 2'd1,
      FLUSH   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  selSync_q;
   logic                    selS;
   logic                    weQ_q;
   logic                    capture;
   logic                    enterProg;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [3:0]              pendBe_q, pendBe_d;
   logic [7:0]              pendAddr_q, pendAddr_d;
   logic [31:0]             pendData_q, pendData_d;
   logic                    wrValid_q, wrValid_d;
   logic [7:0]              wrAddr_q, wrAddr_d;
   logic [31:0]             wrData_q, wrData_d;
   logic [3:0]              wrBe_q, wrBe_d;
   logic                    progDone_q, progDone_d;
   logic [7:0]              capWord;
   logic [3:0]              laneBe;
   logic [31:0]             laneData;
   logic [31:0]             laneMask;
   logic [3:0]              mergedBe;
   logic [31:0]             mergedData;

   // jtag_sel_i comes from the TCK domain. It goes through a plain flop chain
   // before anything in the clk_i domain looks at it. Only the last stage
   // (selS) is used.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         selSync_q <= '0;
      end else begin
         selSync_q <= {selSync_q[SYNC_STAGES-2:0], jtag_sel_i};
      end
   end

   assign selS = selSync_q[SYNC_STAGES-1];

   // The loader holds jtag_we_i high for one or more cycles per byte. Only
   // the rising edge counts as a byte, and only while a session is active.
   // weQ_q is updated in every state. A level that is already high when
   // PROG is entered therefore does not look like a new byte.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         weQ_q <= 1'b0;
      end else begin
         weQ_q <= jtag_we_i;
      end
   end

   assign capture   = jtag_we_i & ~weQ_q & (state_q == PROG);
   assign capWord   = jtag_addr_i[9:2];
   assign laneBe    = 4'b0001 << jtag_addr_i[1:0];
   assign laneData  = 32'(jtag_data_i) << {jtag_addr_i[1:0], 3'b000};
   assign laneMask  = 32'h0000_00FF << {jtag_addr_i[1:0], 3'b000};
   assign mergedBe  = pendBe_q | laneBe;
   assign mergedData = (pendData_q & ~laneMask) | laneData;
   assign enterProg = (state_d == PROG) && (state_q != PROG);

   // Main state register plus the packing buffer and the registered write
   // slot. The pending partial word lives only in these flops. An
   // asynchronous reset in the middle of a session therefore discards it
   // and nothing is written.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= RELEASE;
         cnt_q      <= '0;
         pendBe_q   <= '0;
         pendAddr_q <= '0;
         pendData_q <= '0;
         wrValid_q  <= 1'b0;
         wrAddr_q   <= '0;
         wrData_q   <= '0;
         wrBe_q     <= '0;
         progDone_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pendBe_q   <= pendBe_d;
         pendAddr_q <= pendAddr_d;
         pendData_q <= pendData_d;
         wrValid_q  <= wrValid_d;
         wrAddr_q   <= wrAddr_d;
         wrData_q   <= wrData_d;
         wrBe_q     <= wrBe_d;
         progDone_q <= progDone_d;
      end
   end

   // Next-state logic and byte packing.
   //
   // A captured byte goes into the pending word when the byte belongs to
   // that word. Otherwise the pending word is evicted through the write
   // slot, and a fresh buffer is started with the new byte alone. The
   // non-written lanes of the fresh buffer are zero.
   //
   // A word whose four lanes are all filled is written immediately, one
   // cycle after its last byte.
   //
   // FLUSH normally lasts one cycle. There is one exception: the last PROG
   // cycle may capture a byte that evicts the old word. The eviction then
   // occupies the write port during FLUSH, and the new partial word has to
   // wait. In that case FLUSH holds for one more cycle, so the new partial
   // word is still written and not lost.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pendBe_d   = pendBe_q;
      pendAddr_d = pendAddr_q;
      pendData_d = pendData_q;
      wrValid_d  = 1'b0;
      wrAddr_d   = '0;
      wrData_d   = '0;
      wrBe_d     = '0;
      progDone_d = 1'b0;

      case (state_q)
         RUN: begin
            if (selS) begin
               state_d    = PROG;
               pendBe_d   = '0;
               pendData_d = '0;
               cnt_d      = '0;
            end
         end

         PROG: begin
            if (capture) begin
               if ((pendBe_q != 4'h0) && (capWord != pendAddr_q)) begin
                  wrValid_d  = 1'b1;
                  wrAddr_d   = pendAddr_q;
                  wrData_d   = pendData_q;
                  wrBe_d     = pendBe_q;
                  pendAddr_d = capWord;
                  pendBe_d   = laneBe;
                  pendData_d = laneData;
               end else if (pendBe_q == 4'h0) begin
                  pendAddr_d = capWord;
                  pendBe_d   = laneBe;
                  pendData_d = laneData;
               end else if (mergedBe == 4'hF) begin
                  wrValid_d  = 1'b1;
                  wrAddr_d   = pendAddr_q;
                  wrData_d   = mergedData;
                  wrBe_d     = 4'hF;
                  pendBe_d   = '0;
                  pendData_d = '0;
               end else begin
                  pendBe_d   = mergedBe;
                  pendData_d = mergedData;
               end
            end
            if (!selS) begin
               state_d = FLUSH;
            end
         end

         FLUSH: begin
            if (!(wrValid_q && (pendBe_q != 4'h0))) begin
               state_d    = RELEASE;
               cnt_d      = '0;
               pendBe_d   = '0;
               pendData_d = '0;
            end
         end

         RELEASE: begin
            if (selS) begin
               state_d    = PROG;
               cnt_d      = '0;
               pendBe_d   = '0;
               pendData_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d    = RUN;
               cnt_d      = '0;
               progDone_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = RELEASE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output steering. In RUN the CPU owns the port and its request passes
   // straight through in the same cycle. In every other state the port shows
   // one of two things: the registered loader write from the previous
   // cycle, or, in FLUSH, the leftover partial word. Otherwise the port is
   // idle with all fields zero.
   always_comb begin
      cpu_gnt_o   = 1'b0;
      cpu_rst_no  = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;

      if (state_q == RUN) begin
         cpu_gnt_o   = 1'b1;
         cpu_rst_no  = 1'b1;
         mem_we_o    = cpu_req_i;
         mem_addr_o  = cpu_addr_i;
         mem_wdata_o = cpu_wdata_i;
         mem_be_o    = cpu_be_i;
      end else if (wrValid_q) begin
         mem_we_o    = 1'b1;
         mem_addr_o  = wrAddr_q;
         mem_wdata_o = wrData_q;
         mem_be_o    = wrBe_q;
      end else if ((state_q == FLUSH) && (pendBe_q != 4'h0)) begin
         mem_we_o    = 1'b1;
         mem_addr_o  = pendAddr_q;
         mem_wdata_o = pendData_q;
         mem_be_o    = pendBe_q;
      end
   end

   assign busy_o      = (state_q != RUN);
   assign prog_done_o = progDone_q;

`ifdef PROG_CHECKSUM_EN
   logic [7:0] checksum_q;

   // Running byte sum for the current session. It is cleared when PROG is
   // entered and then held, so software can still read it after the CPU
   // comes out of reset. Entry and capture never coincide, because capture
   // requires the state to already be PROG.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         checksum_q <= '0;
      end else if (enterProg) begin
         checksum_q <= '0;
      end else if (capture) begin
         checksum_q <= checksum_q + jtag_data_i;
      end
   end

   assign checksum_o = checksum_q;
`else
   logic unusedEnterProg;

   // With the checksum disabled there is no sum register. Nothing here
   // uses the session-entry strobe, so it is just collected.
   assign unusedEnterProg = enterProg;
   assign checksum_o      = 8'h00;
`endif

endmodule
